pcie_ingress_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing the single 64-bit ingress AXI-Stream path into the PCIe

---
 rtl/pcie_ingress_arbiter_pkg.sv | 34 +++
 rtl/pcie_ingress_arbiter_skid.sv | 78 +++++++
 rtl/pcie_ingress_arbiter.sv | 140 ++++++++++++++
 tb/tb_pcie_ingress_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_ingress_arbiter_pkg.sv
// Shared types and helpers for the PCIe ingress arbiter: defaults, FSM encoding and
// the rotating-priority pick used to choose the next packet owner.
package pcie_ingress_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned MAX_CH     = 8;
  localparam int unsigned PTR_W      = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  // First requester found scanning upward from ptr+1 with wrap over n channels.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input logic [PTR_W-1:0]  ptr,
                                                input int unsigned       n);
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] idx;
    logic             found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      idx = PTR_W'((32'(ptr) + k) % n);
      if (!found && (k <= n) && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/pcie_ingress_arbiter_skid.sv
// Two-entry skid buffer with registered valid/ready; sustains one beat per cycle
// while the consumer keeps ready high.
module pcie_ingress_arbiter_skid #(
  parameter int unsigned W = 73
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] spare_q, spare_d;
  logic         valid_q, valid_d;
  logic         ready_q, ready_d;
  logic         push, pop;

  // head_q is always the oldest beat; spare_q only fills when the consumer stalls
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    spare_d = spare_q;
    push    = in_valid_i & ready_q;
    pop     = valid_q & out_ready_i;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_data_i;
        end else if (push) begin
          spare_d = in_data_i;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_d  = spare_q;
          count_d = 2'd1;
        end
      end
    endcase
    valid_d = (count_d != 2'd0);
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      spare_q <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      spare_q <= spare_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = head_q;

endmodule

// File: rtl/pcie_ingress_arbiter.sv
// Packet-granular round-robin arbiter feeding the single PCIe ingress AXI-Stream path.
// Grant is held from first beat to TLAST; output is registered through a skid buffer.
module pcie_ingress_arbiter
  import pcie_ingress_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned CH_W   = 2,
  localparam int unsigned KEEP_W = DATA_W / 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic [NUM_CH-1:0]        CH_ENABLE,
  input  logic [NUM_CH-1:0]        S_AXIS_TVALID,
  output logic [NUM_CH-1:0]        S_AXIS_TREADY,
  input  logic [NUM_CH*DATA_W-1:0] S_AXIS_TDATA,
  input  logic [NUM_CH*KEEP_W-1:0] S_AXIS_TKEEP,
  input  logic [NUM_CH-1:0]        S_AXIS_TLAST,
  output logic                     M00_AXIS_TVALID,
  input  logic                     M00_AXIS_TREADY,
  output logic [DATA_W-1:0]        M00_AXIS_TDATA,
  output logic [KEEP_W-1:0]        M00_AXIS_TKEEP,
  output logic                     M00_AXIS_TLAST,
  output logic                     GRANT_VALID,
  output logic [CH_W-1:0]          GRANT_ID,
  output logic [CNT_W-1:0]         PKT_COUNT
);

  localparam int unsigned PLD_W = DATA_W + KEEP_W + 1;

  arb_state_e        state_q, state_d;
  logic [CH_W-1:0]   grant_id_q, grant_id_d;
  logic              grant_valid_q, grant_valid_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;

  logic [NUM_CH-1:0] req;
  logic [CH_W-1:0]   win;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              skid_in_valid;
  logic              skid_in_ready;
  logic              beat_acc;
  logic [PLD_W-1:0]  skid_out;

  // CH_ENABLE only gates new arbitration; an owned packet always runs to TLAST
  assign req = S_AXIS_TVALID & CH_ENABLE;
  assign win = CH_W'(rr_pick(MAX_CH'(req), PTR_W'(ptr_q), NUM_CH));

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_id_q == CH_W'(i)) begin
        sel_valid = S_AXIS_TVALID[i];
        sel_last  = S_AXIS_TLAST[i];
        sel_data  = S_AXIS_TDATA[i*DATA_W +: DATA_W];
        sel_keep  = S_AXIS_TKEEP[i*KEEP_W +: KEEP_W];
      end
    end
  end

  assign skid_in_valid = (state_q == ST_XFER) & sel_valid;
  assign beat_acc      = skid_in_valid & skid_in_ready;

  always_comb begin
    S_AXIS_TREADY = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if ((state_q == ST_XFER) && (grant_id_q == CH_W'(i))) begin
        S_AXIS_TREADY[i] = skid_in_ready;
      end
    end
  end

  // Arbitration FSM: one IDLE cycle between packets picks the next owner
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
    pkt_cnt_d     = pkt_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_id_d    = win;
          grant_valid_d = 1'b1;
          ptr_d         = win;
          state_d       = ST_XFER;
        end
      end
      default: begin
        if (beat_acc && sel_last) begin
          pkt_cnt_d     = pkt_cnt_q + CNT_W'(1);
          grant_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= CH_W'(NUM_CH - 1);
      pkt_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
      pkt_cnt_q     <= pkt_cnt_d;
    end
  end

  pcie_ingress_arbiter_skid #(
    .W (PLD_W)
  ) u_skid (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .in_valid_i  (skid_in_valid),
    .in_ready_o  (skid_in_ready),
    .in_data_i   ({sel_data, sel_keep, sel_last}),
    .out_valid_o (M00_AXIS_TVALID),
    .out_ready_i (M00_AXIS_TREADY),
    .out_data_o  (skid_out)
  );

  assign {M00_AXIS_TDATA, M00_AXIS_TKEEP, M00_AXIS_TLAST} = skid_out;

  assign GRANT_VALID = grant_valid_q;
  assign GRANT_ID    = grant_id_q;
  assign PKT_COUNT   = pkt_cnt_q;

endmodule

// File: tb/tb_pcie_ingress_arbiter.sv
// Directed bench for pcie_ingress_arbiter: a cycle table for the basic packet plus
// packet sources and an expected-beat queue for the multi-cycle scenarios.
module tb_pcie_ingress_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int CH_W   = 2;

  logic                     ACLK = 1'b0;
  logic                     ARESETN;
  logic [NUM_CH-1:0]        CH_ENABLE;
  logic [NUM_CH-1:0]        S_AXIS_TVALID;
  logic [NUM_CH-1:0]        S_AXIS_TREADY;
  logic [NUM_CH*DATA_W-1:0] S_AXIS_TDATA;
  logic [NUM_CH*KEEP_W-1:0] S_AXIS_TKEEP;
  logic [NUM_CH-1:0]        S_AXIS_TLAST;
  logic                     M00_AXIS_TVALID;
  logic                     M00_AXIS_TREADY;
  logic [DATA_W-1:0]        M00_AXIS_TDATA;
  logic [KEEP_W-1:0]        M00_AXIS_TKEEP;
  logic                     M00_AXIS_TLAST;
  logic                     GRANT_VALID;
  logic [CH_W-1:0]          GRANT_ID;
  logic [31:0]              PKT_COUNT;

  always #5 ACLK = ~ACLK;

  pcie_ingress_arbiter #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .CH_W   (CH_W)
  ) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .CH_ENABLE       (CH_ENABLE),
    .S_AXIS_TVALID   (S_AXIS_TVALID),
    .S_AXIS_TREADY   (S_AXIS_TREADY),
    .S_AXIS_TDATA    (S_AXIS_TDATA),
    .S_AXIS_TKEEP    (S_AXIS_TKEEP),
    .S_AXIS_TLAST    (S_AXIS_TLAST),
    .M00_AXIS_TVALID (M00_AXIS_TVALID),
    .M00_AXIS_TREADY (M00_AXIS_TREADY),
    .M00_AXIS_TDATA  (M00_AXIS_TDATA),
    .M00_AXIS_TKEEP  (M00_AXIS_TKEEP),
    .M00_AXIS_TLAST  (M00_AXIS_TLAST),
    .GRANT_VALID     (GRANT_VALID),
    .GRANT_ID        (GRANT_ID),
    .PKT_COUNT       (PKT_COUNT)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic        m_ready;
    logic        mv;
    logic [63:0] data;
    logic        last;
    logic        gv;
    logic [1:0]  gid;
    logic [31:0] cnt;
    logic [3:0]  tr;
  } vec_t;

  beat_t             exp_q[$];
  vec_t              tbl[7];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                beats_out;
  bit                sb_on;
  bit                m_tog;
  int                src_npkt[NUM_CH];
  int                src_len[NUM_CH];
  int                src_pkt[NUM_CH];
  int                src_beat[NUM_CH];
  logic [NUM_CH-1:0] s_fire;
  logic              m_fire;

  function automatic logic [63:0] beat_data(input int ch, input int pkt, input int beat);
    return {8'(ch), 8'(pkt), 48'(beat)};
  endfunction

  // ch0 beat0 yields an all-zero keep, which must pass through untouched
  function automatic logic [7:0] beat_keep(input int ch, input int beat);
    return 8'(beat * 37 + ch * 11);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic src_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      src_npkt[ch] = 0;
      src_len[ch]  = 1;
      src_pkt[ch]  = 0;
      src_beat[ch] = 0;
    end
  endtask

  task automatic drive();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      S_AXIS_TVALID[ch] = (src_pkt[ch] < src_npkt[ch]);
      S_AXIS_TDATA[ch*DATA_W +: DATA_W] = beat_data(ch, src_pkt[ch], src_beat[ch]);
      S_AXIS_TKEEP[ch*KEEP_W +: KEEP_W] = beat_keep(ch, src_beat[ch]);
      S_AXIS_TLAST[ch] = (src_beat[ch] == src_len[ch] - 1);
    end
  endtask

  task automatic advance();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (s_fire[ch]) begin
        if (src_beat[ch] == src_len[ch] - 1) begin
          src_beat[ch] = 0;
          src_pkt[ch]++;
        end else begin
          src_beat[ch]++;
        end
      end
    end
  endtask

  task automatic push_pkt(input int ch, input int pkt, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = beat_data(ch, pkt, i);
      b.keep = beat_keep(ch, i);
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic sample();
    @(negedge ACLK);
    s_fire = S_AXIS_TVALID & S_AXIS_TREADY;
    m_fire = M00_AXIS_TVALID & M00_AXIS_TREADY;
    if (sb_on && M00_AXIS_TVALID) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_beat: got data %0h, expected no beat", M00_AXIS_TDATA);
      end else begin
        check("sb_beat", 128'({M00_AXIS_TDATA, M00_AXIS_TKEEP, M00_AXIS_TLAST}), 128'(exp_q[0]));
        if (m_fire) void'(exp_q.pop_front());
      end
    end
    if (m_fire) beats_out++;
  endtask

  task automatic finish_cycle();
    @(posedge ACLK);
    #1;
    advance();
    drive();
    if (m_tog) M00_AXIS_TREADY = ~M00_AXIS_TREADY;
  endtask

  task automatic step();
    sample();
    finish_cycle();
  endtask

  task automatic do_reset();
    ARESETN         = 1'b0;
    sb_on           = 1'b0;
    m_tog           = 1'b0;
    M00_AXIS_TREADY = 1'b1;
    CH_ENABLE       = '1;
    src_reset();
    drive();
    exp_q.delete();
    beats_out = 0;
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  task automatic run_until_empty(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check({name, "_drain"}, 128'(exp_q.size()), 128'(0));
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // cycle 0 is the first cycle ch0 presents TVALID
    tbl[0] = '{1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 2'd0, 32'd0, 4'b0000};
    tbl[1] = '{1'b1, 1'b0, 64'd0, 1'b0, 1'b1, 2'd0, 32'd0, 4'b0001};
    tbl[2] = '{1'b1, 1'b1, 64'd0, 1'b0, 1'b1, 2'd0, 32'd0, 4'b0001};
    tbl[3] = '{1'b1, 1'b1, 64'd1, 1'b0, 1'b1, 2'd0, 32'd0, 4'b0001};
    tbl[4] = '{1'b1, 1'b1, 64'd2, 1'b0, 1'b1, 2'd0, 32'd0, 4'b0001};
    tbl[5] = '{1'b1, 1'b1, 64'd3, 1'b1, 1'b0, 2'd0, 32'd1, 4'b0000};
    tbl[6] = '{1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 2'd0, 32'd1, 4'b0000};

    ARESETN         = 1'b1;
    CH_ENABLE       = '1;
    M00_AXIS_TREADY = 1'b1;
    sb_on           = 1'b0;
    m_tog           = 1'b0;
    beats_out       = 0;
    src_reset();
    drive();
    #2;
    ARESETN = 1'b0;
    #1;
    check("reset_state", 128'({M00_AXIS_TVALID, M00_AXIS_TDATA, M00_AXIS_TKEEP, M00_AXIS_TLAST,
                               S_AXIS_TREADY, GRANT_VALID, GRANT_ID, PKT_COUNT}), 128'(0));

    // single 4-beat ch0 packet, cycle-exact
    do_reset();
    src_npkt[0] = 1;
    src_len[0]  = 4;
    drive();
    for (int k = 0; k < 7; k++) begin
      M00_AXIS_TREADY = tbl[k].m_ready;
      sample();
      check($sformatf("t1_mvalid[%0d]", k), 128'(M00_AXIS_TVALID), 128'(tbl[k].mv));
      if (tbl[k].mv)
        check($sformatf("t1_beat[%0d]", k),
              128'({M00_AXIS_TDATA, M00_AXIS_TKEEP, M00_AXIS_TLAST}),
              128'({tbl[k].data, beat_keep(0, int'(tbl[k].data)), tbl[k].last}));
      check($sformatf("t1_grant[%0d]", k),
            128'({GRANT_VALID, GRANT_ID, PKT_COUNT, S_AXIS_TREADY}),
            128'({tbl[k].gv, tbl[k].gid, tbl[k].cnt, tbl[k].tr}));
      finish_cycle();
    end

    // all channels requesting: strict rotation 0,1,2,3,0
    do_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      src_npkt[ch] = (ch == 0) ? 2 : 1;
      src_len[ch]  = 2;
    end
    push_pkt(0, 0, 2);
    push_pkt(1, 0, 2);
    push_pkt(2, 0, 2);
    push_pkt(3, 0, 2);
    push_pkt(0, 1, 2);
    sb_on = 1'b1;
    drive();
    run_until_empty(100, "t2");
    check("t2_pkt_count", 128'(PKT_COUNT), 128'(5));

    // downstream ready toggling: no drop, duplication or payload change while stalled
    do_reset();
    m_tog       = 1'b1;
    src_npkt[0] = 1;
    src_len[0]  = 8;
    push_pkt(0, 0, 8);
    sb_on = 1'b1;
    drive();
    run_until_empty(100, "t3");
    check("t3_beats_out", 128'(beats_out), 128'(8));
    check("t3_pkt_count", 128'(PKT_COUNT), 128'(1));

    // channel enable gating, disabled mid-packet
    do_reset();
    CH_ENABLE   = 4'b0010;
    src_npkt[0] = 1;
    src_len[0]  = 4;
    src_npkt[1] = 2;
    src_len[1]  = 4;
    push_pkt(1, 0, 4);
    sb_on = 1'b1;
    drive();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      step();
      if (beats_out >= 1) CH_ENABLE = '0;
    end
    check("t4_drain", 128'(exp_q.size()), 128'(0));
    repeat (20) step();
    check("t4_no_regrant", 128'({GRANT_VALID, GRANT_ID, PKT_COUNT}), 128'({1'b0, 2'd1, 32'd1}));

    // asynchronous reset in the middle of a 6-beat packet
    do_reset();
    src_npkt[0] = 1;
    src_len[0]  = 6;
    push_pkt(0, 0, 6);
    sb_on = 1'b1;
    drive();
    for (int i = 0; i < 40 && beats_out < 2; i++) step();
    check("t5_pre_valid", 128'({M00_AXIS_TVALID, GRANT_VALID}), 128'(2'b11));
    ARESETN = 1'b0;
    #1;
    check("t5_reset_clear", 128'({M00_AXIS_TVALID, S_AXIS_TREADY, GRANT_VALID, PKT_COUNT}), 128'(0));
    do_reset();
    src_npkt[0] = 1;
    src_len[0]  = 2;
    src_npkt[1] = 1;
    src_len[1]  = 2;
    push_pkt(0, 0, 2);
    push_pkt(1, 0, 2);
    sb_on = 1'b1;
    drive();
    run_until_empty(60, "t5");
    check("t5_pkt_count", 128'(PKT_COUNT), 128'(2));

    // packet counter wrap, single-beat packet
    do_reset();
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    @(posedge ACLK);
    #1;
    release dut.pkt_cnt_q;
    check("t6_preload", 128'(PKT_COUNT), 128'(32'hFFFF_FFFF));
    src_npkt[2] = 1;
    src_len[2]  = 1;
    push_pkt(2, 0, 1);
    sb_on = 1'b1;
    drive();
    run_until_empty(40, "t6");
    check("t6_wrap", 128'({GRANT_ID, PKT_COUNT}), 128'({2'd2, 32'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
